// File: rtl/ddr_cmd_responder.sv
// ddr_cmd_responder: DDR4 command decoder with per-bank timing FSMs, violation reporting and BL8 data windows.
// Define RESP_ERR_COUNT_EN to build the saturating violation counter driven onto err_cnt.
module ddr_cmd_responder #(
    parameter int T_RRD = 4,
    parameter int T_RCD = 16,
    parameter int T_RP  = 16,
    parameter int CL    = 16,
    parameter int CWL   = 12
) (
    input  logic        CK_t,
    input  logic        reset_n,
    input  logic        cs_n,
    input  logic        act_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [1:0]  bg,
    input  logic [1:0]  ba,
    input  logic [14:0] row_addr,
    output logic        cmd_act,
    output logic        cmd_pre,
    output logic        cmd_rd,
    output logic        cmd_wr,
    output logic [15:0] bank_open,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [3:0]  err_bank,
    output logic        rd_data_en,
    output logic        wr_data_en,
    output logic [15:0] err_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ACTV = 2'd1, S_OPEN = 2'd2, S_PRE = 2'd3;
    localparam int TMAX = T_RCD > T_RP ? (T_RCD > T_RRD ? T_RCD : T_RRD) : (T_RP > T_RRD ? T_RP : T_RRD);
    localparam int CW = $clog2(TMAX + 1);
    localparam int DW = (CL > CWL ? CL : CWL) + 4;
    logic [1:0]    r_state [16];
    logic [CW-1:0] r_cnt   [16];
    logic [14:0]   r_row   [16];
    logic [CW-1:0] r_rrd;
    logic [DW-1:0] r_rd_sr, r_wr_sr;
    logic [3:0]    w_bank;
    logic [1:0]    w_st;
    logic [2:0]    w_code;
    logic          w_act, w_pre, w_rd, w_wr, w_err;
    assign w_bank = {bg, ba};
    assign w_st   = r_state[w_bank];
    assign w_act  = !cs_n && !act_n;
    assign w_pre  = !cs_n && act_n && {ras_n, cas_n, we_n} == 3'b010;
    assign w_rd   = !cs_n && act_n && {ras_n, cas_n, we_n} == 3'b101;
    assign w_wr   = !cs_n && act_n && {ras_n, cas_n, we_n} == 3'b100;
    // Ternary order encodes "lowest code wins" when several checks fail.
    assign w_code = w_act ? (w_st == S_ACTV || w_st == S_OPEN ? 3'd1 : r_rrd != '0 ? 3'd2 : w_st == S_PRE ? 3'd5 : 3'd0)
                  : (w_rd || w_wr) ? (w_st == S_ACTV ? 3'd3 : w_st != S_OPEN ? 3'd4 : 3'd0) : 3'd0;
    assign w_err  = w_code != 3'd0;
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_row[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_act && !w_err && w_bank == 4'(i)) begin
                    r_state[i] <= S_ACTV;
                    r_cnt[i]   <= CW'(T_RCD - 1);
                    r_row[i]   <= row_addr;
                end else if (w_pre && w_bank == 4'(i) && (r_state[i] == S_ACTV || r_state[i] == S_OPEN)) begin
                    r_state[i] <= S_PRE;
                    r_cnt[i]   <= CW'(T_RP - 1);
                end else if (r_state[i] == S_ACTV || r_state[i] == S_PRE) begin
                    r_state[i] <= r_cnt[i] > CW'(1) ? r_state[i] : (r_state[i] == S_ACTV ? S_OPEN : S_IDLE);
                    r_cnt[i]   <= r_cnt[i] > CW'(1) ? r_cnt[i] - 1'b1 : '0;
                end
            end
        end
    end
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            {cmd_act, cmd_pre, cmd_rd, cmd_wr} <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            err_bank  <= '0;
            r_rrd     <= '0;
            r_rd_sr   <= '0;
            r_wr_sr   <= '0;
        end else begin
            {cmd_act, cmd_pre, cmd_rd, cmd_wr} <= {w_act, w_pre, w_rd, w_wr};
            err_valid <= w_err;
            err_code  <= w_err ? w_code : err_code;
            err_bank  <= w_err ? w_bank : err_bank;
            r_rrd     <= w_act ? CW'(T_RRD - 1) : (r_rrd != '0 ? r_rrd - 1'b1 : r_rrd);
            // Bursts enter at a latency-dependent tap so both windows sit on the top four bits.
            r_rd_sr   <= (r_rd_sr << 1) | (DW'(w_rd && !w_err) << (DW - 4 - CL));
            r_wr_sr   <= (r_wr_sr << 1) | (DW'(w_wr && !w_err) << (DW - 4 - CWL));
        end
    end
    assign rd_data_en = |r_rd_sr[DW-1 -: 4];
    assign wr_data_en = |r_wr_sr[DW-1 -: 4];
    always_comb begin
        bank_open = '0;
        for (int i = 0; i < 16; i++) bank_open[i] = r_state[i] == S_OPEN;
    end
`ifdef RESP_ERR_COUNT_EN
    logic [15:0] r_err_cnt;
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) r_err_cnt <= '0;
        else if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 1'b1;
    end
    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_ddr_cmd_responder.sv
// tb_ddr_cmd_responder: directed DDR4 timing scenarios plus random traffic against a timestamp-based bank model.
module tb_ddr_cmd_responder;
    localparam int T_RRD = 4, T_RCD = 16, T_RP = 16, CL = 16, CWL = 12;
    localparam int K_NOP = 0, K_ACT = 1, K_PRE = 2, K_RD = 3, K_WR = 4, K_OTH = 5;
    logic        CK_t = 0, reset_n = 0, cs_n = 1, act_n = 1, ras_n = 1, cas_n = 1, we_n = 1;
    logic [1:0]  bg = 0, ba = 0;
    logic [14:0] row_addr = 0;
    logic        cmd_act, cmd_pre, cmd_rd, cmd_wr, err_valid, rd_data_en, wr_data_en;
    logic [15:0] bank_open, err_cnt;
    logic [2:0]  err_code;
    logic [3:0]  err_bank;
    int errors = 0, checks = 0, n = 0;
    bit opn[16];
    int t_act[16], t_pre[16];
    int last_act;
    bit rd_hit[0:8191], wr_hit[0:8191];
    logic [3:0]  exp_cmd, exp_bank;
    logic        exp_ev;
    logic [2:0]  exp_code;
    logic [15:0] exp_cnt;

    ddr_cmd_responder #(.T_RRD(T_RRD), .T_RCD(T_RCD), .T_RP(T_RP), .CL(CL), .CWL(CWL)) dut (
        .CK_t(CK_t), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .bg(bg), .ba(ba), .row_addr(row_addr), .cmd_act(cmd_act), .cmd_pre(cmd_pre),
        .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .bank_open(bank_open), .err_valid(err_valid),
        .err_code(err_code), .err_bank(err_bank), .rd_data_en(rd_data_en), .wr_data_en(wr_data_en),
        .err_cnt(err_cnt)
    );

    always #5 CK_t = ~CK_t;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bank state seen by a command at edge n: 0 idle, 1 activating, 2 active, 3 precharging.
    function automatic int bst(int b);
        if (opn[b]) return (n - t_act[b] >= T_RCD) ? 2 : 1;
        return (n - t_pre[b] < T_RP) ? 3 : 0;
    endfunction

    function automatic logic [15:0] open_vec();
        logic [15:0] v;
        for (int b = 0; b < 16; b++) v[b] = opn[b] && (n - t_act[b] >= T_RCD - 1);
        return v;
    endfunction

    task automatic mclear();
        for (int b = 0; b < 16; b++) begin
            opn[b] = 0;
            t_act[b] = -1000;
            t_pre[b] = -1000;
        end
        last_act = -1000;
        for (int i = 0; i < 8192; i++) begin
            rd_hit[i] = 0;
            wr_hit[i] = 0;
        end
        exp_cmd = 0; exp_ev = 0; exp_code = 0; exp_bank = 0; exp_cnt = 0;
    endtask

    task automatic mstep(int k, int b);
        int st, code;
        st = bst(b);
        code = 0;
        exp_cmd = {k == K_ACT, k == K_PRE, k == K_RD, k == K_WR};
        if (k == K_ACT) begin
            code = (st == 1 || st == 2) ? 1 : (n - last_act < T_RRD) ? 2 : (st == 3) ? 5 : 0;
            last_act = n;
            if (code == 0) begin
                opn[b] = 1;
                t_act[b] = n;
            end
        end else if (k == K_PRE && (st == 1 || st == 2)) begin
            opn[b] = 0;
            t_pre[b] = n;
        end else if (k == K_RD || k == K_WR) begin
            code = (st == 1) ? 3 : (st != 2) ? 4 : 0;
            if (code == 0)
                for (int j = 0; j < 4; j++)
                    if (k == K_RD) rd_hit[n + CL + j] = 1;
                    else wr_hit[n + CWL + j] = 1;
        end
        exp_ev = code != 0;
        if (code != 0) begin
            exp_code = 3'(code);
            exp_bank = 4'(b);
`ifdef RESP_ERR_COUNT_EN
            if (exp_cnt != 16'hFFFF) exp_cnt++;
`endif
        end
    endtask

    task automatic check_all();
        chk("cmd_pulses", {cmd_act, cmd_pre, cmd_rd, cmd_wr}, exp_cmd);
        chk("err_valid", err_valid, exp_ev);
        chk("err_code", err_code, exp_code);
        chk("err_bank", err_bank, exp_bank);
        chk("bank_open", bank_open, open_vec());
        chk("rd_data_en", rd_data_en, rd_hit[n]);
        chk("wr_data_en", wr_data_en, wr_hit[n]);
        chk("err_cnt", err_cnt, exp_cnt);
    endtask

    task automatic cyc(int k, int b, logic [14:0] row = 15'h0);
        logic [2:0] rcw;
        rcw = 3'($urandom);
        if (rcw == 3'b010 || rcw == 3'b101 || rcw == 3'b100) rcw = 3'b111;
        cs_n = k == K_NOP;
        act_n = k != K_ACT;
        {ras_n, cas_n, we_n} = k == K_PRE ? 3'b010 : k == K_RD ? 3'b101 : k == K_WR ? 3'b100 : rcw;
        if (k == K_NOP) {act_n, ras_n, cas_n, we_n} = 4'($urandom);
        {bg, ba} = 4'(b);
        row_addr = row;
        @(posedge CK_t);
        n++;
        mstep(k, b);
        @(negedge CK_t);
        check_all();
    endtask

    task automatic nop(int c);
        repeat (c) cyc(K_NOP, $urandom_range(0, 15));
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        mclear();
        chk("rst_outputs", {cmd_act, cmd_pre, cmd_rd, cmd_wr, err_valid, err_code, err_bank, rd_data_en, wr_data_en}, 0);
        chk("rst_bank_open", bank_open, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge CK_t);
        reset_n = 1;
    endtask

    initial begin
        @(negedge CK_t);
        do_reset();
        // ACT then RD exactly tRCD later, followed by burst window edges and a write burst
        cyc(K_ACT, 5, 15'h1234);
        nop(T_RCD - 1);
        cyc(K_RD, 5);
        chk("s1_cmd_rd", cmd_rd, 1);
        chk("s1_no_err", err_valid, 0);
        nop(CL - 1);
        chk("s1_before_burst", rd_data_en, 0);
        repeat (4) begin
            nop(1);
            chk("s1_burst", rd_data_en, 1);
        end
        nop(1);
        chk("s1_after_burst", rd_data_en, 0);
        cyc(K_WR, 5);
        nop(CWL);
        chk("s1_wr_burst", wr_data_en, 1);
        nop(8);
        // tRRD violation leaves the second bank idle
        do_reset();
        cyc(K_ACT, 0);
        nop(1);
        cyc(K_ACT, 1);
        chk("s2_err_valid", err_valid, 1);
        chk("s2_err_code", err_code, 2);
        chk("s2_err_bank", err_bank, 1);
        nop(20);
        chk("s2_bank_open", bank_open, 16'h0001);
        // tRCD violation then legal read
        do_reset();
        cyc(K_ACT, 3);
        nop(4);
        cyc(K_RD, 3);
        chk("s3_err_code", err_code, 3);
        chk("s3_err_valid", err_valid, 1);
        nop(14);
        cyc(K_RD, 3);
        chk("s3_legal_rd", err_valid, 0);
        // tRP violation then legal re-activation
        cyc(K_PRE, 3);
        nop(7);
        cyc(K_ACT, 3);
        chk("s4_err_code", err_code, 5);
        chk("s4_err_valid", err_valid, 1);
        nop(7);
        cyc(K_ACT, 3);
        chk("s4_legal_act", err_valid, 0);
        nop(T_RCD - 2);
        chk("s4_still_opening", bank_open[3], 0);
        nop(1);
        chk("s4_open", bank_open[3], 1);
        // async reset mid-burst with four banks open
        do_reset();
        for (int b = 0; b < 4; b++) begin
            cyc(K_ACT, b);
            nop(T_RRD - 1);
        end
        nop(5);
        cyc(K_RD, 0);
        nop(CL + 1);
        chk("s5_mid_burst", rd_data_en, 1);
        chk("s5_four_open", bank_open, 16'h000F);
        do_reset();
        cyc(K_RD, 0);
        chk("s5_rd_after_reset", err_code, 4);
        chk("s5_rd_after_reset_v", err_valid, 1);
        // random traffic concentrated on a few banks
        do_reset();
        repeat (900) begin
            int r, k;
            r = $urandom_range(0, 9);
            k = r < 4 ? K_NOP : r == 4 ? K_ACT : r == 5 ? K_PRE : r < 8 ? K_RD : r == 8 ? K_WR : K_OTH;
            cyc(k, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3), 15'($urandom));
        end
        nop(CL + 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
